exc_ctl: RTL and testbench
==========================

// Module: exc_ctl
// PURPOSE
//  Exception/interrupt sequencer feeding cp0: arbitrates pipeline exception requests, interrupts, ERET and
//  reset into single-cycle cp0 update strobes (setexl/setexccode/setepc/eret/cold-/softreset), and issues
//  pipeline flush plus fetch redirect to the correct vector. Sits between the WB-stage commit logic and cp0.
// PARAMETERS
//  RESET_HOLD   8   phi2 cycles held in RST after reset deasserts before cold-reset strobe
//  FLUSH_CYCLES 3   phi2 cycles flush stays asserted after any redirect (pipeline drain)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  phi2         in   1   pipeline advance enable; all state changes only when phi2=1
//  stall        in   1   pipeline stall; requests ignored while stall=1
//  softreq      in   1   soft-reset request (level)
//  nmireq       in   1   non-maskable interrupt request (level, edge-detected) [EXC_NMI_EN]
//  excreq       in   1   WB instruction raised synchronous exception
//  exccode      in   5   ExcCode for excreq
//  tlbrefill    in   1   excreq is a TLB/XTLB refill miss
//  xrefill      in   1   refill is 64-bit segment (XTLB vector)
//  wbvalid      in   1   WB holds a valid instruction (interruptible point)
//  wbpc         in   64  PC of WB instruction
//  wbbd         in   1   WB instruction is in a branch delay slot
//  eretreq      in   1   WB instruction is ERET
//  extip        in   5   external interrupt lines (Cause IP6..IP2 equivalents), level
//  cp0status    in   32  cp0 Status
//  cp0cause     in   32  cp0 Cause
//  cp0epc       in   64  cp0 EPC
//  cp0errorepc  in   64  cp0 ErrorEPC
//  cp0setexl    out  1   set Status.EXL
//  cp0setexccode out 6   [5]=write, [4:0]=code
//  cp0setepc    out  66  [65]=write EPC, [64]=BD, [63:0]=EPC/ErrorEPC value
//  cp0coldreset out  1   cold-reset strobe
//  cp0softreset out  1   soft-reset strobe
//  cp0eret      out  1   ERET strobe
//  flush        out  1   kill all in-flight instructions
//  redirect     out  1   one-cycle fetch redirect
//  redirpc      out  64  target PC when redirect=1
// BEHAVIOUR
//  - Reset: all outputs 0, redirpc=0; state RST, hold counter=0; nmi edge register=0.
//  - States: RST -> (counter reaches RESET_HOLD-1) COLD -> RUN; RUN -> FLUSH on any accepted event;
//    FLUSH -> RUN after FLUSH_CYCLES phi2 cycles. Counter increments only on phi2.
//  - COLD (one phi2 cycle): cp0coldreset=1, cp0setepc={2'b00,wbpc}, redirect=1, redirpc=FFFFFFFF_BFC00000, flush=1.
//  - RUN, phi2=1, stall=0: pick highest priority: softreq > NMI > excreq > interrupt > eretreq.
//    Strobes are one-cycle pulses in the accepting cycle; flush asserted from that cycle through FLUSH.
//  - Soft reset: cp0softreset=1, cp0setepc[63:0]=wbpc, [65]=0; redirpc=BFC00000 vector.
//  - excreq: cp0setexl=1; cp0setexccode={1,exccode}; if Status.EXL=0: cp0setepc={1,wbbd,wbbd?wbpc-4:wbpc},
//    else [65]=0 (EPC preserved). Vector base = Status.BEV ? FFFFFFFF_BFC00200 : FFFFFFFF_80000000;
//    offset = (tlbrefill && !EXL) ? (xrefill ? 0x080 : 0x000) : 0x180. 64-bit add, no carry beyond bit 11.
//  - Interrupt: pend = {cause[15], extip, cause[9:8]} & status[15:8]; taken iff |pend && IE && !EXL && !ERL
//    && wbvalid; ExcCode 0, EPC as for excreq, offset 0x180.
//  - ERET: cp0eret=1; redirpc = Status.ERL ? cp0errorepc : cp0epc; no exccode/EPC write.
//  - Requests in FLUSH, RST, COLD, or with stall=1 are ignored (not queued); level sources re-present.
//  - reset asserted mid-FLUSH/any state: returns to RST next clk regardless of phi2.
// CONFIGURATION
//  EXC_NMI_EN defined: nmireq rising edge (sampled on phi2) takes NMI: cp0softreset-style Status update via
//   cp0softreset=0, cp0coldreset=0, cp0setepc ErrorEPC path ([65]=0, value wbpc), redirpc=BFC00000.
//  Undefined: nmireq port present but ignored; no edge register.
// STRUCTURE
//  Shared package/header (cpuconst): Status bit indices IE/EXL/ERL/BEV, ExcCode values, vector constants
//   RESET_VEC, BEV_BASE, NORM_BASE, OFFS_REFILL/XREFILL/GENERAL, state encodings.
//  One sub-module natural: exc_vec (combinational vector/EPC computation); arbitration+FSM in exc_ctl.
// TESTING
//  - reset 1 cycle then phi2 every other clk -> cp0coldreset pulses once after 8 phi2, redirpc=FFFFFFFF_BFC00000.
//  - excreq code 2, tlbrefill=1, EXL=0, BEV=0, wbpc=80001004, wbbd=1 -> setepc={1,1,80001000}, redirpc=FFFFFFFF_80000000.
//  - Same with EXL=1 -> setepc[65]=0, redirpc=...80000180, setexl=1, exccode=6'b100010.
//  - cause[15]=1, status=0000_8001 -> interrupt code 0, redirpc ...80000180; with ERL=1 -> nothing taken.
//  - eretreq with ERL=1, errorepc=A0 -> cp0eret=1, redirpc=A0; new excreq during following 3 phi2 ignored.
//  - softreq and excreq same cycle -> only cp0softreset, no setexl; reset mid-FLUSH -> flush=0 next clk.

Source files
------------

// File: rtl/exc_ctl_pkg.sv
// Shared cp0 constants for the exception sequencer: Status bit
// positions, exception codes, vector bases/offsets and FSM states.
package exc_ctl_pkg;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int ST_ERL = 2;
  localparam int ST_BEV = 22;

  localparam logic [4:0] EXC_INT = 5'd0;

  localparam logic [63:0] RESET_VEC = 64'hFFFF_FFFF_BFC0_0000;
  localparam logic [63:0] BEV_BASE  = 64'hFFFF_FFFF_BFC0_0200;
  localparam logic [63:0] NORM_BASE = 64'hFFFF_FFFF_8000_0000;

  localparam logic [11:0] OFFS_REFILL  = 12'h000;
  localparam logic [11:0] OFFS_XREFILL = 12'h080;
  localparam logic [11:0] OFFS_GENERAL = 12'h180;

  typedef enum logic [1:0] {
    S_RST,
    S_COLD,
    S_RUN,
    S_FLUSH
  } state_t;

endpackage

// File: rtl/exc_ctl_vec.sv
// Exception vector and EPC computation (combinational).
// Offset add is confined to the low 12 bits of the base.
module exc_ctl_vec
  import exc_ctl_pkg::*;
(
  input  logic        i_bev,
  input  logic        i_exl,
  input  logic        i_refill,
  input  logic        i_xrefill,
  input  logic [63:0] i_wbpc,
  input  logic        i_wbbd,
  output logic [63:0] o_vec,
  output logic [63:0] o_epc
);

  logic [63:0] w_base;
  logic [11:0] w_offs;

  always_comb begin
    w_base = i_bev ? BEV_BASE : NORM_BASE;
    w_offs = OFFS_GENERAL;
    if (i_refill && !i_exl)
      w_offs = i_xrefill ? OFFS_XREFILL : OFFS_REFILL;
    o_vec = {w_base[63:12], w_base[11:0] + w_offs};
    o_epc = i_wbbd ? (i_wbpc - 64'd4) : i_wbpc;
  end

endmodule

// File: rtl/exc_ctl.sv
// Exception/interrupt sequencer: arbitrates events into cp0 strobes,
// flush and fetch redirect. Optional NMI support via EXC_NMI_EN.
module exc_ctl
  import exc_ctl_pkg::*;
#(
  parameter int RESET_HOLD   = 8,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_phi2,
  input  logic        i_stall,
  input  logic        i_softreq,
  input  logic        i_nmireq,
  input  logic        i_excreq,
  input  logic [4:0]  i_exccode,
  input  logic        i_tlbrefill,
  input  logic        i_xrefill,
  input  logic        i_wbvalid,
  input  logic [63:0] i_wbpc,
  input  logic        i_wbbd,
  input  logic        i_eretreq,
  input  logic [4:0]  i_extip,
  input  logic [31:0] i_cp0status,
  input  logic [31:0] i_cp0cause,
  input  logic [63:0] i_cp0epc,
  input  logic [63:0] i_cp0errorepc,
  output logic        o_cp0setexl,
  output logic [5:0]  o_cp0setexccode,
  output logic [65:0] o_cp0setepc,
  output logic        o_cp0coldreset,
  output logic        o_cp0softreset,
  output logic        o_cp0eret,
  output logic        o_flush,
  output logic        o_redirect,
  output logic [63:0] o_redirpc
);

  localparam int CW = 8;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  logic        w_nmi_edge;
  logic        w_unused;
  logic        w_exl, w_erl, w_ie;
  logic [7:0]  w_pend;
  logic        w_int_ok, w_acc, w_cold;
  logic        w_soft, w_nmi, w_exc, w_int, w_eret, w_take;
  logic [63:0] w_vec, w_epc;

`ifdef EXC_NMI_EN
  logic r_nmi_q;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_nmi_q <= 1'b0;
    else if (i_phi2)
      r_nmi_q <= i_nmireq;
  end

  assign w_nmi_edge = i_nmireq & ~r_nmi_q;
  assign w_unused   = &{1'b0, i_cp0cause[31:16], i_cp0cause[14:10],
                        i_cp0cause[7:0], i_cp0status[31:23],
                        i_cp0status[21:16], i_cp0status[7:3]};
`else
  assign w_nmi_edge = 1'b0;
  assign w_unused   = &{1'b0, i_nmireq, i_cp0cause[31:16],
                        i_cp0cause[14:10], i_cp0cause[7:0],
                        i_cp0status[31:23], i_cp0status[21:16],
                        i_cp0status[7:3]};
`endif

  assign w_ie  = i_cp0status[ST_IE];
  assign w_exl = i_cp0status[ST_EXL];
  assign w_erl = i_cp0status[ST_ERL];

  assign w_pend   = {i_cp0cause[15], i_extip, i_cp0cause[9:8]}
                  & i_cp0status[15:8];
  assign w_int_ok = (|w_pend) & w_ie & ~w_exl & ~w_erl & i_wbvalid;

  // Priority: soft > nmi > exc > int > eret, only while running.
  assign w_acc  = (r_state == S_RUN) & i_phi2 & ~i_stall;
  assign w_cold = (r_state == S_COLD) & i_phi2;
  assign w_soft = w_acc & i_softreq;
  assign w_nmi  = w_acc & ~i_softreq & w_nmi_edge;
  assign w_exc  = w_acc & ~i_softreq & ~w_nmi_edge & i_excreq;
  assign w_int  = w_acc & ~i_softreq & ~w_nmi_edge & ~i_excreq
                & w_int_ok;
  assign w_eret = w_acc & ~i_softreq & ~w_nmi_edge & ~i_excreq
                & ~w_int_ok & i_eretreq;
  assign w_take = w_soft | w_nmi | w_exc | w_int | w_eret;

  exc_ctl_vec u_vec (
    .i_bev     (i_cp0status[ST_BEV]),
    .i_exl     (w_exl),
    .i_refill  (i_excreq & i_tlbrefill),
    .i_xrefill (i_xrefill),
    .i_wbpc    (i_wbpc),
    .i_wbbd    (i_wbbd),
    .o_vec     (w_vec),
    .o_epc     (w_epc)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_RST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_RST: begin
        if (i_phi2) begin
          if (r_cnt == CW'(RESET_HOLD - 1)) begin
            w_state_nxt = S_COLD;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_COLD: begin
        if (i_phi2)
          w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_take) begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = '0;
        end
      end
      S_FLUSH: begin
        if (i_phi2) begin
          if (r_cnt == CW'(FLUSH_CYCLES - 1)) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_RST;
    endcase
  end

  always_comb begin
    o_cp0setexl     = 1'b0;
    o_cp0setexccode = '0;
    o_cp0setepc     = '0;
    o_cp0coldreset  = 1'b0;
    o_cp0softreset  = 1'b0;
    o_cp0eret       = 1'b0;
    o_redirect      = 1'b0;
    o_redirpc       = '0;
    o_flush         = w_take | w_cold | (r_state == S_FLUSH);
    unique case (1'b1)
      w_cold: begin
        o_cp0coldreset = 1'b1;
        o_cp0setepc    = {2'b00, i_wbpc};
        o_redirect     = 1'b1;
        o_redirpc      = RESET_VEC;
      end
      w_soft: begin
        o_cp0softreset = 1'b1;
        o_cp0setepc    = {2'b00, i_wbpc};
        o_redirect     = 1'b1;
        o_redirpc      = RESET_VEC;
      end
      w_nmi: begin
        o_cp0setepc = {2'b00, i_wbpc};
        o_redirect  = 1'b1;
        o_redirpc   = RESET_VEC;
      end
      w_exc: begin
        o_cp0setexl     = 1'b1;
        o_cp0setexccode = {1'b1, i_exccode};
        o_cp0setepc     = {~w_exl, i_wbbd, w_epc};
        o_redirect      = 1'b1;
        o_redirpc       = w_vec;
      end
      w_int: begin
        o_cp0setexl     = 1'b1;
        o_cp0setexccode = {1'b1, EXC_INT};
        o_cp0setepc     = {1'b1, i_wbbd, w_epc};
        o_redirect      = 1'b1;
        o_redirpc       = w_vec;
      end
      w_eret: begin
        o_cp0eret  = 1'b1;
        o_redirect = 1'b1;
        o_redirpc  = w_erl ? i_cp0errorepc : i_cp0epc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exc_ctl.sv
// Directed bench for exc_ctl: cold reset, exceptions, interrupts,
// ERET, priority and reset during flush.
module tb_exc_ctl;

  logic        i_clk = 1'b0;
  logic        i_reset, i_phi2, i_stall, i_softreq, i_nmireq;
  logic        i_excreq, i_tlbrefill, i_xrefill, i_wbvalid;
  logic [4:0]  i_exccode, i_extip;
  logic [63:0] i_wbpc, i_cp0epc, i_cp0errorepc;
  logic        i_wbbd, i_eretreq;
  logic [31:0] i_cp0status, i_cp0cause;
  logic        o_cp0setexl, o_cp0coldreset, o_cp0softreset;
  logic        o_cp0eret, o_flush, o_redirect;
  logic [5:0]  o_cp0setexccode;
  logic [65:0] o_cp0setepc;
  logic [63:0] o_redirpc;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  exc_ctl dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_phi2(i_phi2),
    .i_stall(i_stall), .i_softreq(i_softreq), .i_nmireq(i_nmireq),
    .i_excreq(i_excreq), .i_exccode(i_exccode),
    .i_tlbrefill(i_tlbrefill), .i_xrefill(i_xrefill),
    .i_wbvalid(i_wbvalid), .i_wbpc(i_wbpc), .i_wbbd(i_wbbd),
    .i_eretreq(i_eretreq), .i_extip(i_extip),
    .i_cp0status(i_cp0status), .i_cp0cause(i_cp0cause),
    .i_cp0epc(i_cp0epc), .i_cp0errorepc(i_cp0errorepc),
    .o_cp0setexl(o_cp0setexl), .o_cp0setexccode(o_cp0setexccode),
    .o_cp0setepc(o_cp0setepc), .o_cp0coldreset(o_cp0coldreset),
    .o_cp0softreset(o_cp0softreset), .o_cp0eret(o_cp0eret),
    .o_flush(o_flush), .o_redirect(o_redirect),
    .o_redirpc(o_redirpc)
  );

  // Inputs change just after posedge; outputs sampled at negedge.
  task automatic adv();
    @(posedge i_clk);
    #1;
  endtask

  task automatic cyc(input logic p2);
    i_phi2 = p2;
    @(negedge i_clk);
  endtask

  task automatic clr_req();
    i_softreq = 0; i_nmireq = 0; i_excreq = 0; i_eretreq = 0;
    i_tlbrefill = 0; i_xrefill = 0; i_stall = 0;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      checks++;
      if ({o_flush, o_redirect} !== 2'b10) begin
        failures++;
        $display("FAIL %s_drain%0d flush/redir=%b exp=10",
                 nm, k, {o_flush, o_redirect});
      end
      adv();
    end
    cyc(1);
    checks++;
    if (o_flush !== 1'b0) begin
      failures++;
      $display("FAIL %s_run flush=%b exp=0", nm, o_flush);
    end
    i_phi2 = 0;
  endtask

  task automatic test_reset();
    int colds, pre;
    logic [63:0] pc;
    i_reset = 1;
    adv();
    cyc(0);
    checks++;
    if ({o_cp0setexl, o_cp0setexccode, o_cp0setepc, o_cp0coldreset,
         o_cp0softreset, o_cp0eret, o_flush, o_redirect, o_redirpc}
        !== '0) begin
      failures++;
      $display("FAIL reset_outs redirpc=%h flush=%b exp=0",
               o_redirpc, o_flush);
    end
    adv();
    i_reset = 0;
    colds = 0; pre = 0; pc = '0;
    for (int i = 0; i < 30; i++) begin
      cyc(i[0] == 1'b0);
      if (o_cp0coldreset) begin
        colds++;
        pc = o_redirpc;
      end else if (i_phi2 && colds == 0) begin
        pre++;
      end
      adv();
    end
    checks++;
    if (colds !== 1) begin
      failures++;
      $display("FAIL cold_pulses got=%0d exp=1", colds);
    end
    checks++;
    if (pre !== 8) begin
      failures++;
      $display("FAIL cold_delay phi2=%0d exp=8", pre);
    end
    checks++;
    if (pc !== 64'hFFFF_FFFF_BFC0_0000) begin
      failures++;
      $display("FAIL cold_vec got=%h exp=FFFFFFFFBFC00000", pc);
    end
  endtask

  task automatic test_excreq();
    i_cp0status = 32'h0; i_excreq = 1; i_exccode = 5'd2;
    i_tlbrefill = 1; i_wbpc = 64'h8000_1004; i_wbbd = 1;
    cyc(1);
    checks++;
    if (o_cp0setepc !== {2'b11, 64'h8000_1000}) begin
      failures++;
      $display("FAIL exc_epc got=%h exp=3_0000000080001000",
               o_cp0setepc);
    end
    checks++;
    if (o_redirpc !== 64'hFFFF_FFFF_8000_0000 || !o_redirect) begin
      failures++;
      $display("FAIL exc_refill_vec got=%h exp=FFFFFFFF80000000",
               o_redirpc);
    end
    adv();
    clr_req();
    drain("exc");
    adv();
    i_cp0status = 32'h2; i_excreq = 1; i_tlbrefill = 1;
    cyc(1);
    checks++;
    if ({o_cp0setepc[65], o_cp0setexl, o_cp0setexccode}
        !== 8'b0_1_100010) begin
      failures++;
      $display("FAIL exc_exl got=%b exp=01100010",
               {o_cp0setepc[65], o_cp0setexl, o_cp0setexccode});
    end
    checks++;
    if (o_redirpc !== 64'hFFFF_FFFF_8000_0180) begin
      failures++;
      $display("FAIL exc_exl_vec got=%h exp=FFFFFFFF80000180",
               o_redirpc);
    end
    adv();
    clr_req();
    drain("exl");
    adv();
    i_cp0status = 32'h0040_0000; i_excreq = 1; i_tlbrefill = 1;
    i_xrefill = 1; i_wbbd = 0; i_wbpc = 64'h1234_5678;
    cyc(1);
    checks++;
    if ({o_cp0setepc, o_redirpc} !==
        {2'b10, 64'h1234_5678, 64'hFFFF_FFFF_BFC0_0280}) begin
      failures++;
      $display("FAIL exc_xrefill_bev epc=%h vec=%h exp=...BFC00280",
               o_cp0setepc, o_redirpc);
    end
    adv();
    clr_req();
    drain("xref");
    adv();
  endtask

  task automatic test_interrupt();
    i_cp0status = 32'h0000_8001; i_cp0cause = 32'h0000_8000;
    i_wbvalid = 1; i_wbpc = 64'h1000; i_wbbd = 0;
    cyc(1);
    checks++;
    if ({o_cp0setexl, o_cp0setexccode, o_cp0setepc, o_redirpc} !==
        {1'b1, 6'b100000, 2'b10, 64'h1000,
         64'hFFFF_FFFF_8000_0180}) begin
      failures++;
      $display("FAIL int_take code=%b epc=%h vec=%h",
               o_cp0setexccode, o_cp0setepc, o_redirpc);
    end
    adv();
    i_cp0status = 32'h0000_8005;
    drain("int");
    adv();
    cyc(1);
    checks++;
    if ({o_redirect, o_flush, o_cp0setexl} !== 3'b000) begin
      failures++;
      $display("FAIL int_erl_block got=%b exp=000",
               {o_redirect, o_flush, o_cp0setexl});
    end
    adv();
    i_cp0status = 32'h0000_8001; i_wbvalid = 0;
    cyc(1);
    checks++;
    if (o_redirect !== 1'b0) begin
      failures++;
      $display("FAIL int_wbvalid redir=%b exp=0", o_redirect);
    end
    adv();
    i_cp0cause = 32'h0; i_wbvalid = 1; i_cp0status = 32'h0;
    i_excreq = 1; i_stall = 1;
    cyc(1);
    checks++;
    if ({o_redirect, o_cp0setexl} !== 2'b00) begin
      failures++;
      $display("FAIL stall_ignore got=%b exp=00",
               {o_redirect, o_cp0setexl});
    end
    adv();
    clr_req();
  endtask

  task automatic test_nmi();
    i_nmireq = 1; i_wbpc = 64'h3000;
    cyc(1);
    checks++;
`ifdef EXC_NMI_EN
    if ({o_redirect, o_cp0setepc, o_redirpc} !==
        {1'b1, 2'b00, 64'h3000, 64'hFFFF_FFFF_BFC0_0000}) begin
      failures++;
      $display("FAIL nmi_take redir=%b vec=%h", o_redirect, o_redirpc);
    end
    adv();
    clr_req();
    drain("nmi");
`else
    if (o_redirect !== 1'b0) begin
      failures++;
      $display("FAIL nmi_ignored redir=%b exp=0", o_redirect);
    end
`endif
    adv();
    clr_req();
  endtask

  task automatic test_eret();
    i_cp0status = 32'h4; i_cp0errorepc = 64'hA0; i_cp0epc = 64'h55;
    i_eretreq = 1;
    cyc(1);
    checks++;
    if ({o_cp0eret, o_cp0setexccode[5], o_cp0setepc[65], o_redirpc}
        !== {3'b100, 64'hA0}) begin
      failures++;
      $display("FAIL eret got=%b pc=%h exp=100 pc=a0",
               {o_cp0eret, o_cp0setexccode[5], o_cp0setepc[65]},
               o_redirpc);
    end
    adv();
    clr_req();
    i_excreq = 1; i_cp0status = 32'h0;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      checks++;
      if ({o_redirect, o_cp0setexl, o_flush} !== 3'b001) begin
        failures++;
        $display("FAIL eret_flush_ignore%0d got=%b exp=001",
                 k, {o_redirect, o_cp0setexl, o_flush});
      end
      adv();
    end
    clr_req();
  endtask

  task automatic test_back_to_back();
    i_softreq = 1; i_excreq = 1; i_wbpc = 64'h2000;
    cyc(1);
    checks++;
    if ({o_cp0softreset, o_cp0setexl, o_cp0setepc, o_redirpc} !==
        {2'b10, 2'b00, 64'h2000, 64'hFFFF_FFFF_BFC0_0000}) begin
      failures++;
      $display("FAIL soft_prio soft=%b exl=%b epc=%h vec=%h",
               o_cp0softreset, o_cp0setexl, o_cp0setepc, o_redirpc);
    end
    adv();
    clr_req();
    cyc(1);
    adv();
    i_reset = 1;
    cyc(0);
    adv();
    cyc(0);
    checks++;
    if (o_flush !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_flush flush=%b exp=0", o_flush);
    end
    i_reset = 0;
  endtask

  initial begin
    i_reset = 1; i_phi2 = 0; clr_req();
    i_exccode = 0; i_wbvalid = 1; i_wbpc = 0; i_wbbd = 0;
    i_extip = 0; i_cp0status = 0; i_cp0cause = 0;
    i_cp0epc = 0; i_cp0errorepc = 0;
    test_reset();
    test_excreq();
    test_interrupt();
    test_nmi();
    test_eret();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
